// File: rtl/control_fsm_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcode constants,
// FSM state encoding, bus/ALU codes, register indices and decode helpers.
package ctrl_pkg;

  localparam int unsigned REG_COUNT   = 11;
  localparam int unsigned IADDR_WIDTH = 8;
  localparam int unsigned INSTR_WIDTH = 8;
  localparam int unsigned REG_IDX_W   = 4;

  // Opcodes live in IR[7:4]; 0xB..0xE are reserved.
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MVAC   = 4'h1;
  localparam logic [3:0] OP_MVR    = 4'h2;
  localparam logic [3:0] OP_LDAC   = 4'h3;
  localparam logic [3:0] OP_STAC   = 4'h4;
  localparam logic [3:0] OP_ADD    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_MUL    = 4'h7;
  localparam logic [3:0] OP_INCAC  = 4'h8;
  localparam logic [3:0] OP_JPNZ   = 4'h9;
  localparam logic [3:0] OP_JUMP   = 4'hA;
  localparam logic [3:0] OP_RSV_LO = 4'hB;
  localparam logic [3:0] OP_RSV_HI = 4'hE;
  localparam logic [3:0] OP_END    = 4'hF;

  // Register-file indices.
  localparam logic [REG_IDX_W-1:0] REG_R      = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_ROW    = 4'd1;
  localparam logic [REG_IDX_W-1:0] REG_CAT    = 4'd2;
  localparam logic [REG_IDX_W-1:0] REG_CB     = 4'd3;
  localparam logic [REG_IDX_W-1:0] REG_RNOW   = 4'd4;
  localparam logic [REG_IDX_W-1:0] REG_CATNOW = 4'd5;
  localparam logic [REG_IDX_W-1:0] REG_CBNOW  = 4'd6;
  localparam logic [REG_IDX_W-1:0] REG_ALPHAP = 4'd7;
  localparam logic [REG_IDX_W-1:0] REG_BETAP  = 4'd8;
  localparam logic [REG_IDX_W-1:0] REG_GAMMAP = 4'd9;
  localparam logic [REG_IDX_W-1:0] REG_TOTAL  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_FWAIT   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MWAIT   = 3'd4,
    ST_OPFETCH = 3'd5,
    ST_OPWAIT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    BUS_REG  = 2'b00,
    BUS_AC   = 2'b01,
    BUS_DMEM = 2'b10,
    BUS_NONE = 2'b11
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_MUL  = 3'b011,
    ALU_INC  = 3'b100
  } alu_op_e;

  // Opcodes whose operand names a register-file entry.
  function automatic logic uses_reg(input logic [3:0] op);
    return (op == OP_MVAC) || (op == OP_MVR) || (op == OP_ADD) ||
           (op == OP_SUB)  || (op == OP_MUL);
  endfunction

  // Reserved opcode, or register operand past the last entry.
  function automatic logic op_illegal(input logic [INSTR_WIDTH-1:0] ir);
    logic [3:0] op;
    op = ir[7:4];
    return ((op >= OP_RSV_LO) && (op <= OP_RSV_HI)) ||
           (uses_reg(op) && (ir[3:0] > REG_TOTAL));
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Sequencer-side bus bundle: program control inputs, instruction-memory
// handshake, register-file selects, ALU/AC controls and data-memory strobes.
//   master : the sequencer (drives strobes, receives start/instr_in/z_flag)
//   slave  : the surrounding core / memories
interface control_fsm_if
  import ctrl_pkg::*;
();
  logic                   start;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   z_flag;
  logic [IADDR_WIDTH-1:0] iram_addr;
  logic                   iram_rd_en;
  logic [REG_COUNT-1:0]   reg_read_en;
  logic [REG_COUNT-1:0]   reg_write_en;
  logic [1:0]             bus_sel;
  logic                   ac_write;
  logic [2:0]             alu_op;
  logic                   dram_rd_en;
  logic                   dram_wr_en;
  logic                   busy;
  logic                   done;
  logic                   illegal;

  modport master (
    input  start, instr_in, z_flag,
    output iram_addr, iram_rd_en, reg_read_en, reg_write_en, bus_sel,
           ac_write, alu_op, dram_rd_en, dram_wr_en, busy, done, illegal
  );

  modport slave (
    output start, instr_in, z_flag,
    input  iram_addr, iram_rd_en, reg_read_en, reg_write_en, bus_sel,
           ac_write, alu_op, dram_rd_en, dram_wr_en, busy, done, illegal
  );
endinterface

// File: rtl/control_fsm_onehot_dec.sv
// Register index to one-hot select; all-zero when disabled or index out of range.
//   i_en       : decode enable
//   i_idx      : register index
//   o_onehot_c : one-hot select (combinational)
module onehot_dec
  import ctrl_pkg::*;
#(
  parameter int unsigned N = REG_COUNT
) (
  input  logic                 i_en,
  input  logic [REG_IDX_W-1:0] i_idx,
  output logic [N-1:0]         o_onehot_c
);

  // Indices >= N never match any bit, so out-of-range yields zero.
  always_comb begin
    o_onehot_c = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot_c[i] = i_en && (i_idx == REG_IDX_W'(i));
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Instruction sequencer: fetches 8-bit instructions, decodes them and drives
// register-file, ALU/AC and data-memory controls. Outputs are registered
// copies of the decode of the next state and next IR, so they line up with
// the state they belong to.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : control_fsm_if.master bundle (start, instr_in, z_flag in;
//           iram/regfile/bus/ALU/dram strobes, busy, done, illegal out)
module control_fsm
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_e                 r_state, w_nxt_state;
  logic [IADDR_WIDTH-1:0] r_pc, w_nxt_pc;
  logic [INSTR_WIDTH-1:0] r_ir, w_nxt_ir;
  logic                   r_illegal, w_nxt_illegal;
  logic [3:0]             w_op, w_nxt_op;

  logic [REG_COUNT-1:0]   r_reg_read_en, r_reg_write_en;
  bus_sel_e               r_bus_sel;
  logic                   r_ac_write;
  alu_op_e                r_alu_op;
  logic                   r_dram_rd_en, r_dram_wr_en;
  logic                   r_iram_rd_en, r_busy, r_done;

  logic                   w_exec, w_nxt_bad;
  logic                   w_rd_dec_en, w_wr_dec_en;
  logic [REG_COUNT-1:0]   w_rd_onehot, w_wr_onehot;
  bus_sel_e               w_bus_sel;
  logic                   w_ac_write;
  alu_op_e                w_alu_op;
  logic                   w_dram_rd, w_dram_wr, w_iram_rd, w_busy, w_done;

  assign w_op = r_ir[7:4];

  // Next state, PC, IR and sticky illegal flag.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_pc      = r_pc;
    w_nxt_ir      = r_ir;
    w_nxt_illegal = r_illegal;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_nxt_state   = ST_FETCH;
          w_nxt_pc      = '0;
          w_nxt_illegal = 1'b0;
        end
      end
      ST_FETCH:   w_nxt_state = ST_FWAIT;
      ST_FWAIT: begin
        w_nxt_ir    = bus.instr_in;
        w_nxt_pc    = r_pc + IADDR_WIDTH'(1);
        w_nxt_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_illegal(r_ir)) w_nxt_illegal = 1'b1;
        case (w_op)
          OP_LDAC:          w_nxt_state = ST_MWAIT;
          OP_JPNZ, OP_JUMP: w_nxt_state = ST_OPFETCH;
          OP_END:           w_nxt_state = ST_IDLE;
          default:          w_nxt_state = ST_FETCH;
        endcase
      end
      ST_MWAIT:   w_nxt_state = ST_FETCH;
      ST_OPFETCH: w_nxt_state = ST_OPWAIT;
      ST_OPWAIT: begin
        // Taken jump loads the operand word; otherwise skip over it.
        if ((w_op == OP_JUMP) || ((w_op == OP_JPNZ) && !bus.z_flag)) begin
          w_nxt_pc = bus.instr_in;
        end else begin
          w_nxt_pc = r_pc + IADDR_WIDTH'(1);
        end
        w_nxt_state = ST_FETCH;
      end
      default:    w_nxt_state = ST_IDLE;
    endcase
  end

  // Output decode from next state and next IR; registered below.
  always_comb begin
    w_nxt_op    = w_nxt_ir[7:4];
    w_exec      = (w_nxt_state == ST_EXEC);
    w_nxt_bad   = op_illegal(w_nxt_ir);
    w_rd_dec_en = 1'b0;
    w_wr_dec_en = 1'b0;
    w_bus_sel   = BUS_NONE;
    w_ac_write  = 1'b0;
    w_alu_op    = ALU_PASS;
    w_dram_rd   = 1'b0;
    w_dram_wr   = 1'b0;
    if (w_exec && !w_nxt_bad) begin
      case (w_nxt_op)
        OP_MVAC: begin
          w_rd_dec_en = 1'b1;
          w_bus_sel   = BUS_REG;
          w_ac_write  = 1'b1;
        end
        OP_MVR: begin
          w_wr_dec_en = 1'b1;
          w_bus_sel   = BUS_AC;
        end
        OP_LDAC: w_dram_rd = 1'b1;
        OP_STAC: begin
          w_bus_sel = BUS_AC;
          w_dram_wr = 1'b1;
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          w_rd_dec_en = 1'b1;
          w_bus_sel   = BUS_REG;
          w_ac_write  = 1'b1;
          w_alu_op    = (w_nxt_op == OP_ADD) ? ALU_ADD :
                        (w_nxt_op == OP_SUB) ? ALU_SUB : ALU_MUL;
        end
        OP_INCAC: begin
          w_ac_write = 1'b1;
          w_alu_op   = ALU_INC;
        end
        default: ;
      endcase
    end
    if (w_nxt_state == ST_MWAIT) begin
      w_bus_sel  = BUS_DMEM;
      w_ac_write = 1'b1;
    end
    w_iram_rd = (w_nxt_state == ST_FETCH) || (w_nxt_state == ST_OPFETCH);
    w_busy    = (w_nxt_state != ST_IDLE);
    w_done    = w_exec && (w_nxt_op == OP_END);
  end

  onehot_dec #(.N(REG_COUNT)) u_rd_dec (
    .i_en       (w_rd_dec_en),
    .i_idx      (w_nxt_ir[3:0]),
    .o_onehot_c (w_rd_onehot)
  );

  onehot_dec #(.N(REG_COUNT)) u_wr_dec (
    .i_en       (w_wr_dec_en),
    .i_idx      (w_nxt_ir[3:0]),
    .o_onehot_c (w_wr_onehot)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_ir           <= '0;
      r_illegal      <= 1'b0;
      r_reg_read_en  <= '0;
      r_reg_write_en <= '0;
      r_bus_sel      <= BUS_NONE;
      r_ac_write     <= 1'b0;
      r_alu_op       <= ALU_PASS;
      r_dram_rd_en   <= 1'b0;
      r_dram_wr_en   <= 1'b0;
      r_iram_rd_en   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_pc           <= w_nxt_pc;
      r_ir           <= w_nxt_ir;
      r_illegal      <= w_nxt_illegal;
      r_reg_read_en  <= w_rd_onehot;
      r_reg_write_en <= w_wr_onehot;
      r_bus_sel      <= w_bus_sel;
      r_ac_write     <= w_ac_write;
      r_alu_op       <= w_alu_op;
      r_dram_rd_en   <= w_dram_rd;
      r_dram_wr_en   <= w_dram_wr;
      r_iram_rd_en   <= w_iram_rd;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  assign bus.iram_addr    = r_pc;
  assign bus.iram_rd_en   = r_iram_rd_en;
  assign bus.reg_read_en  = r_reg_read_en;
  assign bus.reg_write_en = r_reg_write_en;
  assign bus.bus_sel      = r_bus_sel;
  assign bus.ac_write     = r_ac_write;
  assign bus.alu_op       = r_alu_op;
  assign bus.dram_rd_en   = r_dram_rd_en;
  assign bus.dram_wr_en   = r_dram_wr_en;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.illegal      = r_illegal;

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Instruction sequencer for one processor core. It fetches 8-bit instructions from instruction memory, decodes them, and drives the one-hot read/write enables of the core register file. It also drives the bus-source select, the accumulator/ALU controls and the data-memory strobes. It sits directly upstream of the register file and the ALU; one instance per core.

Parameters:
REG_COUNT, 11, number of register-file entries (R, row, cAT, cB, rnow, cATnow, cBnow, alphap, betap, gammap, Total = indices 0..10)
IADDR_WIDTH, 8, instruction-memory address width
INSTR_WIDTH, 8, instruction word width (opcode [7:4], operand [3:0])

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  begin program at address 0; honoured only in IDLE
instr_in  input  8  instruction memory read data, valid the cycle after iram_rd_en
z_flag  input  1  ALU zero flag, sampled for JPNZ
iram_addr  output  8  instruction memory address (= PC)
iram_rd_en  output  1  instruction memory read strobe
reg_read_en  output  REG_COUNT  one-hot register-file read select (all-zero = none)
reg_write_en  output  REG_COUNT  one-hot register-file write enable
bus_sel  output  2  bus source: 00 regfile, 01 AC, 10 data memory, 11 none
ac_write  output  1  load AC from ALU result
alu_op  output  3  000 pass, 001 add, 010 sub, 011 mul, 100 inc
dram_rd_en  output  1  data memory read strobe
dram_wr_en  output  1  data memory write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on END
illegal  output  1  sticky; set on bad opcode/operand, cleared by start or reset

Behaviour:
- Reset (synchronous, active-high): go to IDLE. PC=0, IR=0. All outputs are 0, except bus_sel=11 and iram_addr=0. reset mid-instruction aborts with no further strobes.
- Outputs are Moore, decoded from state and IR. No strobe is asserted outside the states listed below.
- States and transitions:
  - IDLE: on start, PC<=0, clear illegal, go to FETCH.
  - FETCH: iram_addr=PC, iram_rd_en=1; go to FWAIT.
  - FWAIT: IR<=instr_in, PC<=PC+1 (8-bit wrap, 255->0); go to EXEC.
  - EXEC: one cycle; actions by opcode.
  - MWAIT, OPFETCH, OPWAIT: used by LDAC and jumps only.
- Opcodes, with r = IR[3:0]:
  - 0x0 NOP: no strobes.
  - 0x1 MVAC r: reg_read_en[r]=1, bus_sel=00, alu_op=000, ac_write=1.
  - 0x2 MVR r: bus_sel=01, reg_write_en[r]=1.
  - 0x3 LDAC: EXEC asserts dram_rd_en; next state MWAIT. MWAIT asserts bus_sel=10, alu_op=000, ac_write=1.
  - 0x4 STAC: bus_sel=01, dram_wr_en=1.
  - 0x5 ADD r, 0x6 SUB r, 0x7 MUL r: reg_read_en[r]=1, bus_sel=00, alu_op=001/010/011, ac_write=1.
  - 0x8 INCAC: alu_op=100, ac_write=1.
  - 0x9 JPNZ, 0xA JUMP (two-word): EXEC goes to OPFETCH (iram_addr=PC, iram_rd_en=1), then OPWAIT.
  - In OPWAIT, if JUMP, or JPNZ with z_flag==0, then PC<=instr_in; otherwise PC<=PC+1. Then go to FETCH.
  - 0xF END: done=1 in EXEC; go to IDLE.
- Cycle counts (FETCH to next FETCH): 3 for single-cycle ops, 4 for LDAC, 5 for jumps. END: done is asserted in cycle 3, then IDLE.
- Register operand r>=REG_COUNT, or opcodes 0xB–0xE: EXEC asserts no strobes and sets illegal; execution continues with the next instruction.
- At most one bit of reg_read_en and of reg_write_en is set at any time. Read and write are never both nonzero in the same cycle.
- start while busy is ignored. start in the same cycle as reset: reset wins.
- PC wrap: a fetch at 255 continues at 0. An operand fetch at 255 reads address 255, then PC becomes 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - state encoding;
  - bus_sel and alu_op codes;
  - register index constants R..Total (0..10).
- Sub-module onehot_dec: 4-bit index to REG_COUNT one-hot, all-zero when index>=REG_COUNT or enable=0. Two instances, one for read and one for write.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all strobes 0, bus_sel=11, busy=0; start=1 -> iram_addr=0, iram_rd_en=1 on next cycle.
- Program {0x13, 0x27, 0xF0} -> cycle 3: reg_read_en=11'b00000001000, ac_write=1; cycle 6: reg_write_en=11'b00010000000, bus_sel=01; cycle 9: done=1; then busy=0.
- LDAC/STAC {0x30, 0x40, 0xF0} -> dram_rd_en one cycle; next cycle bus_sel=10 with ac_write=1; then dram_wr_en with bus_sel=01; no overlap between strobes.
- Loop {0x8_0, 0x9_0, 0x00, 0xF0} with z_flag=0 three times, then 1 -> PC sequence returns to 0 three times; done fires after the fourth pass.
- Illegal operand 0x1C and opcode 0xB0 -> no reg enables asserted, illegal=1 sticky until next start; execution continues to END.
- Reset asserted during MWAIT of LDAC -> next cycle all strobes 0, state IDLE, PC=0; later start runs cleanly.
